// File: rtl/rf_wb_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wb_ctrl_pkg : shared constants and write-back entry type           |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package rf_wb_ctrl_pkg;
  localparam int DATA_W     = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/rf_wb_ctrl_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_fifo : synchronous FIFO buffering long-latency write-back entries  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module wb_fifo
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == C_DEPTH);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so plain pointer increment wraps correctly
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
`default_nettype wire

// File: rtl/rf_wb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wb_ctrl : register-file write-back arbiter with busy scoreboard    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DATA_W     = rf_wb_ctrl_pkg::DATA_W,
  parameter int NREG       = rf_wb_ctrl_pkg::NREG,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Istall,
  input  logic              Dstall,
  input  logic              wfi_stall,
  input  logic              pipe_valid,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  input  logic [4:0]        lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  input  logic [4:0]        hz_addr_1,
  input  logic [4:0]        hz_addr_2,
  output logic              hz_1,
  output logic              hz_2,
  output logic              RF_write,
  output logic [4:0]        write_addr,
  output logic [DATA_W-1:0] write_data
);
  logic      flag_stall;
  logic      pipe_hit;
  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t fifo_head;
  wb_entry_t lu_entry;

  logic            rf_write_q, rf_write_d;
  wb_entry_t       wb_q, wb_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign flag_stall = Istall | Dstall | wfi_stall;
  assign pipe_hit   = pipe_valid && (pipe_rd != 5'd0);
  assign lu_ready   = !fifo_full;
  // rd==0 results complete the handshake but are never stored
  assign fifo_push  = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign fifo_pop   = !flag_stall && !pipe_hit && !fifo_empty;
  assign lu_entry   = '{rd: lu_rd, data: lu_data};

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_entry(lu_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rf_write_d = rf_write_q;
    wb_d       = wb_q;
    if (!flag_stall) begin
      if (pipe_hit) begin
        rf_write_d = 1'b1;
        wb_d       = '{rd: pipe_rd, data: pipe_data};
      end else if (!fifo_empty) begin
        rf_write_d = 1'b1;
        wb_d       = fifo_head;
      end else begin
        rf_write_d = 1'b0;
      end
    end
  end

  // Clear applied before set so a same-cycle reissue keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) begin
      busy_d[fifo_head.rd] = 1'b0;
    end
    if (iss_valid && !flag_stall && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_q <= 1'b0;
      wb_q       <= '0;
      busy_q     <= '0;
    end else begin
      rf_write_q <= rf_write_d;
      wb_q       <= wb_d;
      busy_q     <= busy_d;
    end
  end

  assign hz_1       = (hz_addr_1 != 5'd0) && busy_q[hz_addr_1];
  assign hz_2       = (hz_addr_2 != 5'd0) && busy_q[hz_addr_2];
  assign RF_write   = rf_write_q;
  assign write_addr = wb_q.rd;
  assign write_data = wb_q.data;
endmodule
`default_nettype wire

// File: tb/tb_rf_wb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rf_wb_ctrl : directed plus random bench against a queue model      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_rf_wb_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              Istall, Dstall, wfi_stall;
  logic              pipe_valid;
  logic [4:0]        pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [4:0]        lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic [4:0]        hz_addr_1, hz_addr_2;
  logic              hz_1, hz_2;
  logic              RF_write;
  logic [4:0]        write_addr;
  logic [DATA_W-1:0] write_data;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: pending long-latency results as {rd,data} in arrival order
  logic [36:0] m_q[$];
  bit          m_busy[32];
  logic        m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          last_acc;

  always #5 clk = ~clk;

  rf_wb_ctrl #(
    .DATA_W    (DATA_W),
    .NREG      (32),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Istall    (Istall),
    .Dstall    (Dstall),
    .wfi_stall (wfi_stall),
    .pipe_valid(pipe_valid),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .hz_addr_1 (hz_addr_1),
    .hz_addr_2 (hz_addr_2),
    .hz_1      (hz_1),
    .hz_2      (hz_2),
    .RF_write  (RF_write),
    .write_addr(write_addr),
    .write_data(write_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wr   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic check_all();
    check("rf_write", RF_write, m_wr);
    check("write_addr", write_addr, m_addr);
    check("write_data", write_data, m_data);
    check("lu_ready", lu_ready, m_q.size() < DEPTH);
    check("hz_1", hz_1, (hz_addr_1 != 0) && m_busy[hz_addr_1]);
    check("hz_2", hz_2, (hz_addr_2 != 0) && m_busy[hz_addr_2]);
  endtask

  // One clock: evaluate the rules on the pre-edge inputs, then compare
  task automatic step();
    bit          stall, acc, popped;
    logic [36:0] e;
    stall  = Istall | Dstall | wfi_stall;
    acc    = lu_valid && (m_q.size() < DEPTH);
    popped = 1'b0;
    @(posedge clk);
    #1;
    if (!stall) begin
      if (pipe_valid && pipe_rd != 0) begin
        m_wr = 1'b1; m_addr = pipe_rd; m_data = pipe_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        popped = 1'b1;
        m_wr = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
        m_busy[e[36:32]] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
    if (acc && lu_rd != 0) m_q.push_back({lu_rd, lu_data});
    last_acc = acc;
    check_all();
  endtask

  task automatic idle();
    pipe_valid = 0; lu_valid = 0; iss_valid = 0;
    Istall = 0; Dstall = 0; wfi_stall = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    pipe_rd = 0; pipe_data = 0; lu_rd = 0; lu_data = 0; iss_rd = 0;
    hz_addr_1 = 5'd7; hz_addr_2 = 5'd12;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_write", RF_write, 1'b0);
    check("rst_addr", write_addr, 5'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_lu_ready", lu_ready, 1'b1);
    check("rst_hz_1", hz_1, 1'b0);
    check("rst_hz_2", hz_2, 1'b0);
    rst = 1'b0;

    // Pipeline write then idle
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    step();
    check("t1_write", {RF_write, write_addr, write_data}, {1'b1, 5'd5, 32'hDEADBEEF});
    idle(); step();
    check("t1_idle", RF_write, 1'b0);

    // Scoreboard set by issue, cleared by long-latency write-back
    iss_valid = 1; iss_rd = 7; step();
    iss_valid = 0;
    check("t2_hz_set", hz_1, 1'b1);
    lu_valid = 1; lu_rd = 7; lu_data = 32'h1234; step();
    lu_valid = 0;
    check("t2_no_bypass", RF_write, 1'b0);
    step();
    check("t2_lu_write", {RF_write, write_addr, write_data}, {1'b1, 5'd7, 32'h1234});
    check("t2_hz_clear", hz_1, 1'b0);

    // Fill FIFO behind continuous pipeline writes, then drain
    pipe_valid = 1; pipe_rd = 20; pipe_data = 32'hA0;
    lu_valid = 1; lu_rd = 3; lu_data = 32'h33; step();
    lu_rd = 4; lu_data = 32'h44; step();
    lu_valid = 0;
    check("t3_full", lu_ready, 1'b0);
    pipe_data = 32'hA1; step();
    check("t3_pipe_only", write_addr, 5'd20);
    pipe_valid = 0; step();
    check("t3_drain_3", write_addr, 5'd3);
    step();
    check("t3_drain_4", write_addr, 5'd4);
    check("t3_ready", lu_ready, 1'b1);

    // Stall freezes WB and FIFO
    pipe_valid = 1; pipe_rd = 9; pipe_data = 32'h99;
    lu_valid = 1; lu_rd = 11; lu_data = 32'hBB; step();
    idle(); Dstall = 1;
    repeat (3) begin
      step();
      check("t4_hold", {RF_write, write_addr}, {1'b1, 5'd9});
    end
    Dstall = 0; step();
    check("t4_resume", write_addr, 5'd11);

    // Same-cycle reissue beats pop clear
    idle(); iss_valid = 1; iss_rd = 12; step();
    iss_valid = 0; lu_valid = 1; lu_rd = 12; lu_data = 32'hCC; step();
    lu_valid = 0; iss_valid = 1; step();
    iss_valid = 0;
    check("t5_busy_kept", hz_2, 1'b1);

    // rd==0 on pipe lets FIFO pop; rd==0 long-latency is dropped
    lu_valid = 1; lu_rd = 2; lu_data = 32'h22; step();
    pipe_valid = 1; pipe_rd = 0; lu_rd = 0; lu_data = 32'hFF; step();
    check("t6_pop_on_x0", write_addr, 5'd2);
    idle(); step();
    check("t6_x0_dropped", RF_write, 1'b0);

    // Random traffic with a mid-run asynchronous reset
    last_acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      Istall     = ($urandom_range(0, 9) == 0);
      Dstall     = ($urandom_range(0, 9) == 0);
      wfi_stall  = ($urandom_range(0, 19) == 0);
      pipe_valid = ($urandom_range(0, 2) == 0);
      pipe_rd    = 5'($urandom_range(0, 31));
      pipe_data  = $urandom;
      if (last_acc || !lu_valid) begin
        lu_valid = ($urandom_range(0, 1) == 0);
        lu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lu_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      hz_addr_1 = 5'($urandom_range(0, 31));
      hz_addr_2 = 5'($urandom_range(0, 31));
      if (i == 1500) begin
        rst = 1'b1;
        #2;
        model_reset();
        check("mid_rst_rf_write", RF_write, 1'b0);
        check("mid_rst_addr", write_addr, 5'd0);
        check("mid_rst_ready", lu_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lu_valid = 1'b0;
        check_all();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
- Write-back controller that drives the register file write port (RF_write, write_addr, write_data).
- Merges in-order single-cycle pipeline results with out-of-order results from a long-latency unit (load/mul-div). The long-latency results pass through a small FIFO.
- Keeps a per-register busy scoreboard and reports read hazards to decode.
- Sits between EX/MEM and the register file. It obeys the same stall semantics as the register file, so no write is ever presented while the register file would ignore it.

Parameters:
- DATA_W, 32, result width.
- NREG, 32, architectural register count (x0 hardwired zero).
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- Istall  in  1  instruction-side stall.
- Dstall  in  1  data-side stall.
- wfi_stall  in  1  wait-for-interrupt stall.
- pipe_valid  in  1  pipeline result valid this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  DATA_W  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_rd  in  5  long-latency destination.
- lu_data  in  DATA_W  long-latency result.
- lu_ready  out  1  FIFO can accept (combinational, = !full).
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  5  its destination.
- hz_addr_1  in  5  decode source address 1.
- hz_addr_2  in  5  decode source address 2.
- hz_1  out  1  source 1 pending (combinational).
- hz_2  out  1  source 2 pending (combinational).
- RF_write  out  1  register file write enable (registered).
- write_addr  out  5  write address (registered).
- write_data  out  DATA_W  write data (registered).

Behaviour:
- flag_stall = Istall | Dstall | wfi_stall.
- Reset:
  - RF_write=0, write_addr=0, write_data=0.
  - Busy vector all 0, FIFO empty (rd/wr pointers 0, count 0).
  - lu_ready=1, hz_1=hz_2=0.
- WB register, while flag_stall=1:
  - Holds its value. No pop occurs and busy clears are suppressed.
- WB register, when flag_stall=0, loads by priority at each edge:
  1. pipe_valid && pipe_rd!=0 → {1, pipe_rd, pipe_data}.
  2. else FIFO non-empty → pop head, load {1, head.rd, head.data}.
  3. else → RF_write=0; write_addr/write_data hold their last value.
- pipe_valid with pipe_rd==0 counts as no pipeline result, so the FIFO may pop that cycle.
- FIFO push:
  - Occurs on lu_valid && lu_ready && lu_rd!=0, independent of flag_stall.
  - lu_rd==0 results are accepted (handshake completes) and discarded.
- No FIFO bypass: a pushed entry is poppable at the earliest on the next edge. Minimum latency lu_valid→RF_write is 2 edges.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full FIFO: lu_ready=0. The producer holds lu_valid/lu_rd/lu_data stable until accepted.
- Pointers wrap modulo FIFO_DEPTH. Count is tracked separately (width clog2(FIFO_DEPTH)+1) to distinguish full from empty.
- Scoreboard:
  - Set: busy[iss_rd] on iss_valid && !flag_stall && iss_rd!=0.
  - Clear: busy[head.rd] on a FIFO pop.
  - Set and clear of the same rd in the same cycle → set wins.
  - busy[0] is always 0.
- hz_k = busy[hz_addr_k] (0 for address 0).
- Decode stalls on hz. Pipeline bubbles (pipe_valid=0) therefore let the FIFO drain, and back-to-back pipeline writes only delay long-latency write-back, never lose it.
- Pipeline and long-latency writes to the same rd are ordered by the issue stage (hazard on busy). This block does not reorder or check them.
- Reset asserted mid-operation clears all state immediately: pending FIFO entries are lost and busy bits are cleared.

Decomposition:
- Shared package constants: DATA_W, NREG, REG_ADDR_W=5.
- Shared package typedef: wb_entry_t {logic [4:0] rd; logic [DATA_W-1:0] data;}, used by the FIFO and the WB register.
- Sub-module: wb_fifo (parameterised sync FIFO with push/pop/full/empty/head). Scoreboard and WB register stay in the top.

Test Plan:
1. Reset, then pipe_valid=1, rd=5, data=0xDEADBEEF → next edge RF_write=1, write_addr=5, write_data=0xDEADBEEF; following idle cycle RF_write=0.
2. iss_valid rd=7, then hz_addr_1=7 → hz_1=1. Then lu_valid rd=7, data=0x1234 with no pipe traffic → RF_write with addr 7 two edges after lu_valid; hz_1 drops on the same edge.
3. FIFO holds 2 entries (rd 3, rd 4) while pipe_valid=1 every cycle → lu_ready=0, and only pipe writes appear. Drop pipe_valid → rd 3 then rd 4 written on consecutive edges, and lu_ready returns to 1.
4. Dstall=1 for 3 cycles with WB holding rd=9 and FIFO non-empty → WB outputs constant, no pop, busy unchanged. Release → pop resumes on the next edge.
5. Same-cycle iss_valid rd=12 and FIFO pop of rd=12 → busy[12] remains 1.
6. pipe_valid with rd=0 plus FIFO head rd=2 → FIFO entry written (addr 2). lu_valid with rd=0 → accepted, never written, count unchanged.
